tc_sram_banked: RTL

Multi-requester, word-interleaved banked SRAM. It generalises the single- and dual-port `tc_sram` to any number of requester ports, 1..8, served by a power-of-two number of single-port banks. Each bank has a round-robin arbiter, a same-cycle grant, and a `rvalid` response pipeline of configurable latency. It sits between clusters of cores/DMA masters and on-chip scratchpad memory; for FPGA targets it is built only from `NumPorts=1` storage macros.

---
 rtl/tc_sram_banked_pkg.sv | 26 ++
 rtl/tc_sram.sv | 75 +++++++
 rtl/tc_sram_banked_arb.sv | 56 +++++
 rtl/tc_sram_banked.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tc_sram_banked_pkg.sv
// -----------------------------------------------------------------------------
// tc_sram_banked_pkg
// Shared helpers for the banked SRAM: ceiling division, index widths and the
// layout of one response-pipeline stage. Width-dependent typedefs live in the
// modules that know the widths.
// -----------------------------------------------------------------------------
package tc_sram_banked_pkg;

  // Ceiling division for byte-lane counts.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Width needed to index n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A response stage carries {valid, is_read, oob} flags plus a bank index.
  localparam int StageFlagBits = 3;

  function automatic int stage_width(input int num_banks);
    return StageFlagBits + idx_width(num_banks);
  endfunction

endpackage

// File: rtl/tc_sram.sv
// -----------------------------------------------------------------------------
// tc_sram
// Single-port behavioural SRAM used as one bank of tc_sram_banked. A read
// issued in cycle t presents its data on rdata_o in cycle t+Latency; writes
// apply byte-lane enables and are visible to reads in the following cycle.
// Only the NumPorts=1 configuration is provided.
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset (read pipeline only)
//   req_i    access request
//   we_i     1 = write, 0 = read
//   addr_i   word address
//   wdata_i  write data
//   be_i     byte-lane write enables
//   rdata_o  read data, Latency cycles after the read request
// -----------------------------------------------------------------------------
module tc_sram
  import tc_sram_banked_pkg::*;
#(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned NumPorts  = 1,
  parameter int unsigned Latency   = 1,
  parameter int unsigned AddrWidth = idx_width(NumWords),
  parameter int unsigned BeWidth   = ceil_div(DataWidth, ByteWidth)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumPorts-1:0]           req_i,
  input  logic [NumPorts-1:0]           we_i,
  input  logic [NumPorts*AddrWidth-1:0] addr_i,
  input  logic [NumPorts*DataWidth-1:0] wdata_i,
  input  logic [NumPorts*BeWidth-1:0]   be_i,
  output logic [NumPorts*DataWidth-1:0] rdata_o
);

  if (NumPorts != 1) begin : g_bad_ports
    $fatal(1, "tc_sram: only NumPorts=1 is provided");
  end
  if (Latency < 1) begin : g_bad_latency
    $fatal(1, "tc_sram: Latency must be at least 1");
  end

  logic [DataWidth-1:0] mem_q   [NumWords];
  logic [DataWidth-1:0] rdata_q [Latency];
  logic                 in_range;

  assign in_range = (32'(addr_i) < 32'(NumWords));

  // NOTE: the storage array has no reset; clearing a RAM would turn it into
  // flops. Contents after reset are simply undefined.
  always_ff @(posedge clk_i) begin
    if (req_i[0] && we_i[0] && in_range) begin
      for (int i = 0; i < int'(DataWidth); i++) begin
        if (be_i[i / int'(ByteWidth)]) mem_q[addr_i][i] <= wdata_i[i];
      end
    end
  end

  // Stage 0 captures on reads only; later stages shift every cycle so the
  // read issued in cycle t reaches the last stage exactly Latency cycles on.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < int'(Latency); s++) rdata_q[s] <= '0;
    end else begin
      if (req_i[0] && !we_i[0] && in_range) rdata_q[0] <= mem_q[addr_i];
      for (int s = 1; s < int'(Latency); s++) rdata_q[s] <= rdata_q[s-1];
    end
  end

  assign rdata_o = rdata_q[Latency-1];

endmodule

// File: rtl/tc_sram_banked_arb.sv
// -----------------------------------------------------------------------------
// tc_sram_banked_arb
// Round-robin arbiter for one bank. The winner is the first requester at or
// above the priority pointer, searching upward with wrap. After a grant the
// pointer moves just past the winner; with no grant it holds.
//
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset (pointer returns to 0)
//   req_i   per-port candidate requests for this bank
//   gnt_o   one-hot (or zero) grant, combinational from req_i and pointer
// -----------------------------------------------------------------------------
module tc_sram_banked_arb
  import tc_sram_banked_pkg::*;
#(
  parameter int unsigned NumPorts = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPorts-1:0] req_i,
  output logic [NumPorts-1:0] gnt_o
);

  localparam int PtrW = idx_width(NumPorts);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] winner;
  logic [PtrW-1:0] idx;
  logic            found;

  // NOTE: every combinational output gets a default at the top of the block so
  // no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    gnt_o  = '0;
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 0; i < int'(NumPorts); i++) begin
      idx = PtrW'((int'(ptr_q) + i) % int'(NumPorts));
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    if (found) gnt_o[winner] = 1'b1;
    ptr_d = found ? PtrW'((int'(winner) + 1) % int'(NumPorts)) : ptr_q;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/tc_sram_banked.sv
// -----------------------------------------------------------------------------
// tc_sram_banked
// Word-interleaved banked SRAM shared by NumPorts requesters. The low address
// bits pick the bank, the rest pick the row. Each bank has its own
// round-robin arbiter and grants in the same cycle; every grant produces one
// rvalid_o pulse Latency cycles later on the granted port.
//
// Ports:
//   clk_i     clock
//   rst_ni    asynchronous active-low reset
//   req_i     per-port request
//   gnt_o     per-port grant (combinational)
//   we_i      per-port write enable
//   addr_i    per-port word address, packed NumPorts x AddrWidth
//   wdata_i   per-port write data, packed NumPorts x DataWidth
//   be_i      per-port byte enables, packed NumPorts x BeWidth
//   rvalid_o  per-port response valid
//   rdata_o   per-port read data (zero unless a valid in-range read)
// -----------------------------------------------------------------------------
module tc_sram_banked
  import tc_sram_banked_pkg::*;
#(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned NumPorts  = 4,
  parameter int unsigned NumBanks  = 4,
  parameter int unsigned Latency   = 1,
  parameter int unsigned AddrWidth = idx_width(NumWords),
  parameter int unsigned BeWidth   = ceil_div(DataWidth, ByteWidth)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumPorts-1:0]           req_i,
  output logic [NumPorts-1:0]           gnt_o,
  input  logic [NumPorts-1:0]           we_i,
  input  logic [NumPorts*AddrWidth-1:0] addr_i,
  input  logic [NumPorts*DataWidth-1:0] wdata_i,
  input  logic [NumPorts*BeWidth-1:0]   be_i,
  output logic [NumPorts-1:0]           rvalid_o,
  output logic [NumPorts*DataWidth-1:0] rdata_o
);

  if ((NumBanks == 0) || ((NumBanks & (NumBanks - 1)) != 0)) begin : g_bad_banks
    $fatal(1, "tc_sram_banked: NumBanks must be a power of two");
  end
  if ((NumBanks != 0) && (NumWords % NumBanks != 0)) begin : g_bad_words
    $fatal(1, "tc_sram_banked: NumWords must be a multiple of NumBanks");
  end
  if ((NumPorts < 1) || (NumPorts > 8)) begin : g_bad_ports
    $fatal(1, "tc_sram_banked: NumPorts must be 1..8");
  end
  if (Latency < 1) begin : g_bad_latency
    $fatal(1, "tc_sram_banked: Latency must be at least 1");
  end

  localparam int BankBits     = $clog2(NumBanks);
  localparam int BankIdxW     = idx_width(NumBanks);
  localparam int WordsPerBank = NumWords / NumBanks;
  localparam int BankAddrW    = idx_width(WordsPerBank);

  typedef struct packed {
    logic                valid;
    logic                is_read;
    logic                oob;
    logic [BankIdxW-1:0] bank;
  } stage_t;

  // ---------------------------------------------------------------------------
  // Per-port address decode
  // ---------------------------------------------------------------------------
  logic [AddrWidth-1:0] port_addr [NumPorts];
  logic [BankIdxW-1:0]  port_bank [NumPorts];
  logic [BankAddrW-1:0] port_row  [NumPorts];
  logic [NumPorts-1:0]  port_oob;

  always_comb begin
    port_oob = '0;
    for (int p = 0; p < int'(NumPorts); p++) begin
      port_addr[p] = addr_i[p*AddrWidth +: AddrWidth];
      // NumBanks is a power of two, so the mask is the bank field.
      port_bank[p] = BankIdxW'(port_addr[p] & AddrWidth'(NumBanks - 1));
      port_row[p]  = BankAddrW'(port_addr[p] >> BankBits);
      // Only reachable when NumWords is not a power of two.
      port_oob[p]  = (32'(port_addr[p]) >= 32'(NumWords));
    end
  end

  // ---------------------------------------------------------------------------
  // Banks: arbiter, request mux, storage
  // ---------------------------------------------------------------------------
  logic [NumPorts-1:0]  bank_gnt   [NumBanks];
  logic [DataWidth-1:0] bank_rdata [NumBanks];

  for (genvar b = 0; b < int'(NumBanks); b++) begin : g_bank
    logic [NumPorts-1:0]  cand;
    logic [NumPorts-1:0]  gnt;
    logic                 bank_req;
    logic                 bank_we;
    logic [BankAddrW-1:0] bank_addr;
    logic [DataWidth-1:0] bank_wdata;
    logic [BeWidth-1:0]   bank_be;

    always_comb begin
      cand = '0;
      for (int p = 0; p < int'(NumPorts); p++) begin
        cand[p] = req_i[p] && (port_bank[p] == BankIdxW'(b));
      end
    end

    tc_sram_banked_arb #(
      .NumPorts (NumPorts)
    ) u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (cand),
      .gnt_o  (gnt)
    );

    // An out-of-range winner is still granted but never reaches the bank, so
    // its write is dropped and its row index cannot overrun the array.
    always_comb begin
      bank_req   = 1'b0;
      bank_we    = 1'b0;
      bank_addr  = '0;
      bank_wdata = '0;
      bank_be    = '0;
      for (int p = 0; p < int'(NumPorts); p++) begin
        if (gnt[p]) begin
          bank_req   = !port_oob[p];
          bank_we    = we_i[p];
          bank_addr  = port_row[p];
          bank_wdata = wdata_i[p*DataWidth +: DataWidth];
          bank_be    = be_i[p*BeWidth +: BeWidth];
        end
      end
    end

    tc_sram #(
      .NumWords  (WordsPerBank),
      .DataWidth (DataWidth),
      .ByteWidth (ByteWidth),
      .NumPorts  (1),
      .Latency   (Latency)
    ) u_sram (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req_i   (bank_req),
      .we_i    (bank_we),
      .addr_i  (bank_addr),
      .wdata_i (bank_wdata),
      .be_i    (bank_be),
      .rdata_o (bank_rdata[b])
    );

    assign bank_gnt[b] = gnt;

    a_one_grant : assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(gnt))
      else $error("tc_sram_banked: more than one grant in bank %0d", b);
  end

  always_comb begin
    gnt_o = '0;
    for (int b = 0; b < int'(NumBanks); b++) gnt_o = gnt_o | bank_gnt[b];
  end

  // ---------------------------------------------------------------------------
  // Response pipeline: tracks each grant so the last stage knows whether to
  // pulse rvalid_o and which bank output (if any) to return.
  // ---------------------------------------------------------------------------
  stage_t pipe_q [NumPorts][Latency];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < int'(NumPorts); p++)
        for (int s = 0; s < int'(Latency); s++) pipe_q[p][s] <= '0;
    end else begin
      for (int p = 0; p < int'(NumPorts); p++) begin
        pipe_q[p][0] <= '{valid:   gnt_o[p],
                          is_read: !we_i[p],
                          oob:     port_oob[p],
                          bank:    port_bank[p]};
        for (int s = 1; s < int'(Latency); s++) pipe_q[p][s] <= pipe_q[p][s-1];
      end
    end
  end

  stage_t last;

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    last     = '0;
    for (int p = 0; p < int'(NumPorts); p++) begin
      last        = pipe_q[p][Latency-1];
      rvalid_o[p] = last.valid;
      if (last.valid && last.is_read && !last.oob)
        rdata_o[p*DataWidth +: DataWidth] = bank_rdata[last.bank];
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
  a_gnt_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (gnt_o & ~req_i) == '0)
    else $error("tc_sram_banked: grant without request");

  for (genvar p = 0; p < int'(NumPorts); p++) begin : g_stable
    a_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_i[p] && !gnt_o[p]) |=>
        (req_i[p] && $stable(we_i[p])
         && $stable(addr_i[p*AddrWidth +: AddrWidth])
         && $stable(wdata_i[p*DataWidth +: DataWidth])
         && $stable(be_i[p*BeWidth +: BeWidth])))
      else $error("tc_sram_banked: port %0d changed request while denied", p);
  end

endmodule
